// File: rtl/service_packet_dispatcher.sv
// Service packet dispatcher: routes decoded SPI service packets to the MIL-1553
// transmit buffer, drains the receive buffer into SPI replies and reports status.
module service_packet_dispatcher #(
    parameter logic [7:0] OWN_ADDR   = 8'hAB,
    parameter logic [7:0] BCAST_ADDR = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pkt_start,
    input  logic [7:0]  pkt_addr,
    input  logic [7:0]  pkt_cmd,
    input  logic [15:0] pkt_size,
    input  logic        pkt_end,
    input  logic        pkt_err,
    input  logic        in_req,
    input  logic [15:0] in_data,
    output logic        tx_push,
    output logic [15:0] tx_data,
    input  logic        tx_full,
    output logic        tx_commit,
    output logic        tx_rollback,
    input  logic [9:0]  rx_count,
    output logic        rx_pop,
    input  logic [15:0] rx_data,
    output logic        reply_req,
    output logic [15:0] reply_data,
    output logic        reply_last,
    input  logic        reply_ready,
    output logic        buf_clear
);

    localparam logic [7:0] TCC_SEND_DATA    = 8'hA2;
    localparam logic [7:0] TCC_RECEIVE_DATA = 8'hB3;
    localparam logic [7:0] TCC_GET_STATUS   = 8'hC4;
    localparam logic [7:0] TCC_RESET        = 8'hD5;

    typedef enum logic [3:0] {
        IDLE,
        SEND,
        DROP,
        WAIT_END,
        STATUS,
        RX_POP,
        RX_WAIT,
        RX_PUSH,
        CLEAR
    } state_t;

    state_t      state;
    state_t      start_state;
    logic [7:0]  cmd;
    logic [15:0] size;
    logic [9:0]  n;
    logic [9:0]  n_load;
    logic        overflow;
    logic [6:0]  err_cnt;
    logic [6:0]  err_next;
    logic        err_inc;
    logic        err_clr;
    logic        commit_pend;
    logic [7:0]  rx_sat;
    logic [15:0] status_word;
    logic        addr_own;
    logic        addr_bc;

    // Decode of a newly started packet; used from IDLE and when a new start aborts a packet.
    always_comb begin
        addr_own    = (pkt_addr == OWN_ADDR);
        addr_bc     = (pkt_addr == BCAST_ADDR);
        start_state = DROP;
        case (pkt_cmd)
            TCC_SEND_DATA: begin
                if (addr_own || addr_bc) start_state = SEND;
            end
            TCC_RESET: begin
                if (addr_own || addr_bc) start_state = WAIT_END;
            end
            TCC_RECEIVE_DATA, TCC_GET_STATUS: begin
                if (addr_own) start_state = WAIT_END;
            end
            default: start_state = DROP;
        endcase
    end

    always_comb begin
        n_load      = (size < {6'b0, rx_count}) ? size[9:0] : rx_count;
        rx_sat      = (rx_count > 10'd255) ? 8'hFF : rx_count[7:0];
        status_word = {overflow, err_cnt, rx_sat};
    end

    // Error counting: aborts in SEND/WAIT_END and starts that arrive while busy replying.
    always_comb begin
        err_inc = 1'b0;
        case (state)
            SEND, WAIT_END:                          err_inc = pkt_err || pkt_start;
            STATUS, RX_POP, RX_WAIT, RX_PUSH, CLEAR: err_inc = pkt_start;
            default:                                 err_inc = 1'b0;
        endcase
        err_clr  = ((state == STATUS) && reply_req && reply_ready) || (state == CLEAR);
        err_next = err_cnt;
        if (err_clr) begin
            err_next = err_inc ? 7'd1 : 7'd0;
        end else if (err_inc && (err_cnt != 7'd127)) begin
            err_next = err_cnt + 7'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cmd         <= '0;
            size        <= '0;
            n           <= '0;
            overflow    <= 1'b0;
            err_cnt     <= '0;
            commit_pend <= 1'b0;
            tx_push     <= 1'b0;
            tx_data     <= '0;
            tx_commit   <= 1'b0;
            tx_rollback <= 1'b0;
            rx_pop      <= 1'b0;
            reply_req   <= 1'b0;
            reply_data  <= '0;
            reply_last  <= 1'b0;
            buf_clear   <= 1'b0;
        end else begin
            tx_push     <= 1'b0;
            tx_commit   <= commit_pend;
            commit_pend <= 1'b0;
            tx_rollback <= 1'b0;
            rx_pop      <= 1'b0;
            buf_clear   <= 1'b0;
            err_cnt     <= err_next;

            if (pkt_start && ((state == IDLE) || (state == SEND) ||
                              (state == DROP) || (state == WAIT_END))) begin
                cmd  <= pkt_cmd;
                size <= pkt_size;
            end

            case (state)
                IDLE: begin
                    if (pkt_start) state <= start_state;
                end

                SEND: begin
                    if (pkt_err || pkt_start) begin
                        tx_rollback <= 1'b1;
                        state       <= pkt_start ? start_state : IDLE;
                    end else begin
                        if (in_req) begin
                            if (tx_full) begin
                                overflow <= 1'b1;
                            end else begin
                                tx_push <= 1'b1;
                                tx_data <= in_data;
                            end
                        end
                        // A word arriving with the end pulse is pushed first; commit trails it.
                        if (pkt_end) begin
                            state <= IDLE;
                            if (in_req && !tx_full) commit_pend <= 1'b1;
                            else                    tx_commit   <= 1'b1;
                        end
                    end
                end

                DROP: begin
                    if (pkt_start)              state <= start_state;
                    else if (pkt_end || pkt_err) state <= IDLE;
                end

                WAIT_END: begin
                    if (pkt_start) begin
                        state <= start_state;
                    end else if (pkt_err) begin
                        state <= IDLE;
                    end else if (pkt_end) begin
                        case (cmd)
                            TCC_RECEIVE_DATA: begin
                                if (n_load == 10'd0) begin
                                    reply_req  <= 1'b1;
                                    reply_data <= status_word;
                                    reply_last <= 1'b1;
                                    state      <= STATUS;
                                end else begin
                                    n      <= n_load;
                                    rx_pop <= 1'b1;
                                    state  <= RX_POP;
                                end
                            end
                            TCC_GET_STATUS: begin
                                reply_req  <= 1'b1;
                                reply_data <= status_word;
                                reply_last <= 1'b1;
                                state      <= STATUS;
                            end
                            TCC_RESET: begin
                                buf_clear <= 1'b1;
                                state     <= CLEAR;
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end

                STATUS: begin
                    if (reply_ready) begin
                        reply_req  <= 1'b0;
                        reply_last <= 1'b0;
                        overflow   <= 1'b0;
                        state      <= IDLE;
                    end
                end

                RX_POP: begin
                    state <= RX_WAIT;
                end

                RX_WAIT: begin
                    reply_req  <= 1'b1;
                    reply_data <= rx_data;
                    reply_last <= (n == 10'd1);
                    state      <= RX_PUSH;
                end

                RX_PUSH: begin
                    if (reply_ready) begin
                        reply_req  <= 1'b0;
                        reply_last <= 1'b0;
                        if (n == 10'd1) begin
                            state <= IDLE;
                        end else begin
                            n      <= n - 10'd1;
                            rx_pop <= 1'b1;
                            state  <= RX_POP;
                        end
                    end
                end

                CLEAR: begin
                    overflow <= 1'b0;
                    state    <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_service_packet_dispatcher.sv
// Scoreboard bench for service_packet_dispatcher: stimulus queues expected output
// events, a negedge monitor pops and compares them as the DUT produces them.
module tb_service_packet_dispatcher;

    localparam logic [2:0] EV_PUSH   = 3'd0;
    localparam logic [2:0] EV_COMMIT = 3'd1;
    localparam logic [2:0] EV_ROLL   = 3'd2;
    localparam logic [2:0] EV_POP    = 3'd3;
    localparam logic [2:0] EV_CLEAR  = 3'd4;
    localparam logic [2:0] EV_REPLY  = 3'd5;

    typedef struct packed {
        logic [2:0]  kind;
        logic [15:0] data;
        logic        last;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pkt_start = 1'b0;
    logic [7:0]  pkt_addr = '0;
    logic [7:0]  pkt_cmd = '0;
    logic [15:0] pkt_size = '0;
    logic        pkt_end = 1'b0;
    logic        pkt_err = 1'b0;
    logic        in_req = 1'b0;
    logic [15:0] in_data = '0;
    logic        tx_full = 1'b0;
    logic [9:0]  rx_count = '0;
    logic [15:0] rx_data = '0;
    logic        reply_ready = 1'b1;
    logic        tx_push, tx_commit, tx_rollback, rx_pop, reply_req, reply_last, buf_clear;
    logic [15:0] tx_data, reply_data;

    int   total = 0;
    int   bad = 0;
    int   pop_total = 0;
    int   exp_pops = 0;
    int   ready_mode = 0;
    ev_t  exp_q[$];

    always #5 clk = ~clk;

    service_packet_dispatcher #(.OWN_ADDR(8'hAB), .BCAST_ADDR(8'hFF)) dut (
        .clk(clk), .rst(rst),
        .pkt_start(pkt_start), .pkt_addr(pkt_addr), .pkt_cmd(pkt_cmd), .pkt_size(pkt_size),
        .pkt_end(pkt_end), .pkt_err(pkt_err), .in_req(in_req), .in_data(in_data),
        .tx_push(tx_push), .tx_data(tx_data), .tx_full(tx_full),
        .tx_commit(tx_commit), .tx_rollback(tx_rollback),
        .rx_count(rx_count), .rx_pop(rx_pop), .rx_data(rx_data),
        .reply_req(reply_req), .reply_data(reply_data), .reply_last(reply_last),
        .reply_ready(reply_ready), .buf_clear(buf_clear)
    );

    // reply_ready: 0 = always ready, 1 = toggle each cycle, otherwise held low
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       reply_ready = 1'b1;
            1:       reply_ready = ~reply_ready;
            default: reply_ready = 1'b0;
        endcase
    end

    task automatic check_ev(input logic [2:0] k, input logic [15:0] d, input logic l,
                            input string name);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: unexpected event kind=%0d data=%h, none required", name, k, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== k || e.data !== d || e.last !== l) begin
                bad++;
                $display("FAIL %s: got kind=%0d data=%h last=%b required kind=%0d data=%h last=%b",
                         name, k, d, l, e.kind, e.data, e.last);
            end
        end
    endtask

    always @(negedge clk) begin
        if (tx_push) check_ev(EV_PUSH, tx_data, 1'b0, "tx_push");
        if (tx_commit) begin
            total++;
            if (tx_push !== 1'b0) begin
                bad++;
                $display("FAIL commit_with_push: tx_push=%b required 0", tx_push);
            end
            check_ev(EV_COMMIT, 16'h0000, 1'b0, "tx_commit");
        end
        if (tx_rollback) check_ev(EV_ROLL, 16'h0000, 1'b0, "tx_rollback");
        if (buf_clear) check_ev(EV_CLEAR, 16'h0000, 1'b0, "buf_clear");
        if (rx_pop) begin
            check_ev(EV_POP, 16'h0000, 1'b0, "rx_pop");
            pop_total++;
            rx_data = 16'hA000 + 16'(pop_total);
        end
        if (reply_req) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL reply: unexpected data=%h last=%b, none required", reply_data, reply_last);
            end else if (exp_q[0].kind !== EV_REPLY || exp_q[0].data !== reply_data ||
                         exp_q[0].last !== reply_last) begin
                bad++;
                $display("FAIL reply: got data=%h last=%b required kind=%0d data=%h last=%b",
                         reply_data, reply_last, exp_q[0].kind, exp_q[0].data, exp_q[0].last);
                if (reply_ready) void'(exp_q.pop_front());
            end else if (reply_ready) begin
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic expect_ev(input logic [2:0] k, input logic [15:0] d, input logic l);
        ev_t e;
        e.kind = k;
        e.data = d;
        e.last = l;
        exp_q.push_back(e);
    endtask

    task automatic expect_rx_word(input logic l);
        exp_pops++;
        expect_ev(EV_POP, 16'h0000, 1'b0);
        expect_ev(EV_REPLY, 16'hA000 + 16'(exp_pops), l);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [7:0] a, input logic [7:0] c, input logic [15:0] s);
        pkt_start = 1'b1; pkt_addr = a; pkt_cmd = c; pkt_size = s;
        tick();
        pkt_start = 1'b0;
    endtask

    task automatic word(input logic [15:0] d);
        in_req = 1'b1; in_data = d;
        tick();
        in_req = 1'b0;
    endtask

    task automatic pend();
        pkt_end = 1'b1;
        tick();
        pkt_end = 1'b0;
    endtask

    task automatic perr();
        pkt_err = 1'b1;
        tick();
        pkt_err = 1'b0;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        repeat (4) tick();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_%s: pending=%0d required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_push", {15'b0, tx_push}, 16'h0);
        chk("rst_tx_data", tx_data, 16'h0);
        chk("rst_tx_commit", {15'b0, tx_commit}, 16'h0);
        chk("rst_tx_rollback", {15'b0, tx_rollback}, 16'h0);
        chk("rst_rx_pop", {15'b0, rx_pop}, 16'h0);
        chk("rst_reply_req", {15'b0, reply_req}, 16'h0);
        chk("rst_reply_data", reply_data, 16'h0);
        chk("rst_reply_last", {15'b0, reply_last}, 16'h0);
        chk("rst_buf_clear", {15'b0, buf_clear}, 16'h0);
        rst = 1'b0;
        tick();

        // plain send
        expect_ev(EV_PUSH, 16'hEFAB, 1'b0);
        expect_ev(EV_PUSH, 16'h0001, 1'b0);
        expect_ev(EV_COMMIT, 16'h0000, 1'b0);
        start(8'hAB, 8'hA2, 16'd2);
        word(16'hEFAB);
        word(16'h0001);
        pend();
        drain("send");

        // overflow on the middle word, then rollback; status twice
        expect_ev(EV_PUSH, 16'h1111, 1'b0);
        expect_ev(EV_PUSH, 16'h3333, 1'b0);
        expect_ev(EV_ROLL, 16'h0000, 1'b0);
        start(8'hAB, 8'hA2, 16'd3);
        word(16'h1111);
        tx_full = 1'b1;
        word(16'h2222);
        tick();
        tx_full = 1'b0;
        word(16'h3333);
        perr();
        drain("overflow");
        rx_count = 10'd5;
        expect_ev(EV_REPLY, 16'h8105, 1'b1);
        start(8'hAB, 8'hC4, 16'd0);
        pend();
        drain("status1");
        expect_ev(EV_REPLY, 16'h0005, 1'b1);
        start(8'hAB, 8'hC4, 16'd0);
        pend();
        drain("status2");

        // address filter and broadcast rules
        start(8'hAC, 8'hA2, 16'd2);
        word(16'h4444);
        word(16'h5555);
        pend();
        start(8'hFF, 8'hC4, 16'd0);
        pend();
        drain("filter");
        expect_ev(EV_CLEAR, 16'h0000, 1'b0);
        start(8'hFF, 8'hD5, 16'd0);
        pend();
        drain("bcast_reset");

        // receive limited by rx_count, with a stalling consumer
        rx_count = 10'd3;
        ready_mode = 1;
        expect_rx_word(1'b0);
        expect_rx_word(1'b0);
        expect_rx_word(1'b1);
        start(8'hAB, 8'hB3, 16'd5);
        pend();
        drain("receive");
        ready_mode = 0;

        // WAIT_END error, then receive with empty buffer answers with status
        start(8'hAB, 8'hC4, 16'd0);
        perr();
        rx_count = 10'd0;
        expect_ev(EV_REPLY, 16'h0100, 1'b1);
        start(8'hAB, 8'hB3, 16'd4);
        pend();
        drain("rx_empty");

        // end and error together: error wins
        expect_ev(EV_PUSH, 16'h1234, 1'b0);
        expect_ev(EV_ROLL, 16'h0000, 1'b0);
        start(8'hAB, 8'hA2, 16'd1);
        word(16'h1234);
        pkt_end = 1'b1; pkt_err = 1'b1;
        tick();
        pkt_end = 1'b0; pkt_err = 1'b0;
        drain("end_err");

        // new start mid-send aborts the old packet and runs the new one
        expect_ev(EV_PUSH, 16'h5555, 1'b0);
        expect_ev(EV_ROLL, 16'h0000, 1'b0);
        expect_ev(EV_PUSH, 16'h6666, 1'b0);
        expect_ev(EV_COMMIT, 16'h0000, 1'b0);
        start(8'hAB, 8'hA2, 16'd2);
        word(16'h5555);
        start(8'hAB, 8'hA2, 16'd1);
        word(16'h6666);
        pend();
        drain("restart");

        // last word together with end: push then commit a cycle later
        expect_ev(EV_PUSH, 16'h7777, 1'b0);
        expect_ev(EV_COMMIT, 16'h0000, 1'b0);
        start(8'hAB, 8'hA2, 16'd1);
        in_req = 1'b1; in_data = 16'h7777; pkt_end = 1'b1;
        tick();
        in_req = 1'b0; pkt_end = 1'b0;
        drain("word_end");

        // err_cnt=2 and rx_count saturated at 255
        rx_count = 10'd300;
        expect_ev(EV_REPLY, 16'h02FF, 1'b1);
        start(8'hAB, 8'hC4, 16'd0);
        pend();
        drain("status_sat");

        // reset while a reply word is stalled
        ready_mode = 2;
        rx_count = 10'd2;
        expect_rx_word(1'b0);
        start(8'hAB, 8'hB3, 16'd2);
        pend();
        n = 0;
        while (!reply_req && n < 20) begin
            tick();
            n++;
        end
        chk("rst_wait_reply", {15'b0, reply_req}, 16'h1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_reply_req", {15'b0, reply_req}, 16'h0);
        exp_q.delete();
        ready_mode = 0;
        tick();
        expect_ev(EV_REPLY, 16'h0002, 1'b1);
        start(8'hAB, 8'hC4, 16'd0);
        pend();
        drain("post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
